// File: rtl/spi_pkg.sv
// spi_pkg: shared state encodings, SPI mode constants and the chip-select width helper.
package spi_pkg;

    localparam logic [1:0] SPI_IDLE  = 2'd0;
    localparam logic [1:0] SPI_SETUP = 2'd1;
    localparam logic [1:0] SPI_XFER  = 2'd2;
    localparam logic [1:0] SPI_HOLD  = 2'd3;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int spi_cs_width(input int n_cs);
        if (n_cs > 1) begin
            return $clog2(n_cs);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: emits a one-cycle tick every CLK_DIV clocks while enabled (one SCLK half-period).
module spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == CNT_LAST);

    // Half-period counter; held at zero whenever the engine is idle so every transfer starts aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI master with configurable word width, SCLK divider, chip-select count and CPOL/CPHA.
// Defining SPI_LOOPBACK_EN adds the loop_en port (internal mosi->sample path, chip selects held high).
module spi_master
    import spi_pkg::*;
#(
    parameter int W_DATA  = 8,
    parameter int N_CS    = 2,
    parameter int CLK_DIV = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [W_DATA-1:0]             tx_data,
    input  logic [spi_cs_width(N_CS)-1:0] cs_sel,
    input  logic [1:0]                    mode,
`ifdef SPI_LOOPBACK_EN
    input  logic                          loop_en,
`endif
    output logic                          rx_valid,
    output logic [W_DATA-1:0]             rx_data,
    output logic                          busy,
    output logic                          sclk,
    output logic                          mosi,
    input  logic                          miso,
    output logic [N_CS-1:0]               cs_n
);

    localparam int EDGE_W = $clog2(2 * W_DATA);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * W_DATA - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [1:0]        mode_r;
    logic              loop_r;
    logic              loop_in_s;
    logic [W_DATA-1:0] sh_r;
    logic              rx_bit_r;
    logic [EDGE_W-1:0] edge_cnt_r;
    logic              tick_s;
    logic              accept_s;
    logic              last_edge_s;
    logic              lead_s;
    logic              sample_s;
    logic [N_CS-1:0]   cs_dec_s;

    logic              busy_r;
    logic              rx_valid_r;
    logic [W_DATA-1:0] rx_data_r;
    logic              sclk_r;
    logic              mosi_r;
    logic [N_CS-1:0]   cs_n_r;

`ifdef SPI_LOOPBACK_EN
    assign loop_in_s = loop_en;
`else
    assign loop_in_s = 1'b0;
`endif

    assign tx_ready    = (state_r == SPI_IDLE);
    assign accept_s    = tx_valid && tx_ready;
    assign last_edge_s = (edge_cnt_r == EDGE_LAST);
    // SCLK still sits at its idle level, so the coming toggle is a leading edge
    assign lead_s      = (sclk_r == mode_r[1]);
    assign sample_s    = loop_r ? mosi_r : miso;

    assign busy     = busy_r;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
    assign sclk     = sclk_r;
    assign mosi     = mosi_r;
    assign cs_n     = cs_n_r;

    spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_r != SPI_IDLE),
        .tick (tick_s)
    );

    // Chip-select pattern for the request being accepted; out-of-range selects match no bit
    always_comb begin
        cs_dec_s = '1;
        for (int i = 0; i < N_CS; i++) begin
            cs_dec_s[i] = loop_in_s || (int'(cs_sel) != i);
        end
    end

    // Next-state decode; every non-idle state advances only on a divider tick
    always_comb begin
        state_s = state_r;
        case (state_r)
            SPI_IDLE: begin
                if (accept_s) begin
                    state_s = SPI_SETUP;
                end else begin
                    state_s = SPI_IDLE;
                end
            end
            SPI_SETUP: begin
                if (tick_s) begin
                    state_s = SPI_XFER;
                end else begin
                    state_s = SPI_SETUP;
                end
            end
            SPI_XFER: begin
                if (tick_s && last_edge_s) begin
                    state_s = SPI_HOLD;
                end else begin
                    state_s = SPI_XFER;
                end
            end
            SPI_HOLD: begin
                if (tick_s) begin
                    state_s = SPI_IDLE;
                end else begin
                    state_s = SPI_HOLD;
                end
            end
            default: begin
                state_s = SPI_IDLE;
            end
        endcase
    end

    // Serial engine: request latch, SCLK generation, shift register and result hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= SPI_IDLE;
            mode_r     <= SPI_MODE0;
            loop_r     <= 1'b0;
            sh_r       <= '0;
            rx_bit_r   <= 1'b0;
            edge_cnt_r <= '0;
            busy_r     <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= '0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            cs_n_r     <= '1;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != SPI_IDLE);
            rx_valid_r <= 1'b0;
            case (state_r)
                SPI_IDLE: begin
                    if (accept_s) begin
                        mode_r     <= mode;
                        loop_r     <= loop_in_s;
                        sh_r       <= tx_data;
                        mosi_r     <= tx_data[W_DATA-1];
                        sclk_r     <= mode[1];
                        cs_n_r     <= cs_dec_s;
                        edge_cnt_r <= '0;
                    end
                end
                SPI_SETUP: begin
                end
                SPI_XFER: begin
                    if (tick_s) begin
                        sclk_r     <= ~sclk_r;
                        edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
                        if (mode_r[0]) begin
                            // CPHA=1: present on leading, capture on trailing
                            if (lead_s) begin
                                mosi_r <= sh_r[W_DATA-1];
                            end else begin
                                sh_r <= {sh_r[W_DATA-2:0], sample_s};
                            end
                        end else begin
                            // CPHA=0: capture on leading, shift on trailing; the bit waits in rx_bit_r
                            if (lead_s) begin
                                rx_bit_r <= sample_s;
                            end else begin
                                sh_r <= {sh_r[W_DATA-2:0], rx_bit_r};
                                if (!last_edge_s) begin
                                    mosi_r <= sh_r[W_DATA-2];
                                end
                            end
                        end
                    end
                end
                SPI_HOLD: begin
                    if (tick_s) begin
                        cs_n_r     <= '1;
                        rx_data_r  <= sh_r;
                        rx_valid_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench; a rule-level SPI slave model drives miso and records mosi.
module tb_spi_master;

    localparam int W       = 8;
    localparam int CLK_DIV = 2;
    localparam int LAT     = 1 + CLK_DIV * (2 * W + 2);

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_valid, tx_ready, rx_valid, busy, sclk, mosi, miso;
    logic [7:0]   tx_data, rx_data;
    logic [0:0]   cs_sel;
    logic [1:0]   mode, cs_n;

    logic         tx_valid3, tx_ready3, rx_valid3, busy3, sclk3, mosi3, miso3;
    logic [7:0]   tx_data3, rx_data3;
    logic [1:0]   cs_sel3, mode3;
    logic [2:0]   cs_n3;
`ifdef SPI_LOOPBACK_EN
    logic         loop_en, loop_en3;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // slave model state
    logic [7:0] slv_word, mon_slv, mon_cap;
    logic [1:0] slv_mode, mon_mode;
    int         mon_edges, mon_bad, mon_idx;
    logic       prev_busy, prev_sclk, prev_mosi, lead, shift_edge;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.W_DATA(8), .N_CS(2), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .cs_sel(cs_sel), .mode(mode),
`ifdef SPI_LOOPBACK_EN
        .loop_en(loop_en),
`endif
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_master #(.W_DATA(8), .N_CS(3), .CLK_DIV(2)) dut3 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_data(tx_data3),
        .cs_sel(cs_sel3), .mode(mode3),
`ifdef SPI_LOOPBACK_EN
        .loop_en(loop_en3),
`endif
        .rx_valid(rx_valid3), .rx_data(rx_data3), .busy(busy3), .sclk(sclk3), .mosi(mosi3),
        .miso(miso3), .cs_n(cs_n3)
    );

    // Slave: presents its word MSB first, shifting on the mode's shift edge; records mosi on sample edges
    initial begin
        miso = 1'b0; prev_busy = 1'b0; prev_sclk = 1'b0; prev_mosi = 1'b0;
        mon_edges = 0; mon_bad = 0; mon_idx = 0; mon_cap = 8'h00; mon_slv = 8'h00; mon_mode = 2'b00;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                mon_slv = slv_word; mon_mode = slv_mode;
                mon_edges = 0; mon_cap = 8'h00; mon_bad = 0;
                mon_idx = mon_mode[0] ? 8 : 7;
                miso = mon_mode[0] ? 1'b0 : mon_slv[7];
            end else if (busy === 1'b1) begin
                if (sclk !== prev_sclk) begin
                    mon_edges++;
                    lead = (sclk !== mon_mode[1]);
                    shift_edge = (lead == mon_mode[0]);
                    if (!shift_edge) begin
                        mon_cap = {mon_cap[6:0], mosi};
                    end else if (mon_idx > 0 && mon_edges < 2 * W) begin
                        mon_idx--;
                        miso = mon_slv[mon_idx];
                    end
                    if (mosi !== prev_mosi && !shift_edge) mon_bad++;
                end else if (mosi !== prev_mosi) begin
                    mon_bad++;
                end
            end
            prev_busy = busy; prev_sclk = sclk; prev_mosi = mosi;
        end
    end

    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slv, input logic [1:0] md,
                           input logic sel, output int t0, output int t_rx,
                           output logic [1:0] cs_first, output logic cs_steady);
        int n;
        slv_word = slv; slv_mode = md;
        @(negedge clk);
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        tx_valid = 1'b1; tx_data = tx; mode = md; cs_sel = sel;
        t0 = cyc;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'($urandom); mode = 2'($urandom); cs_sel = 1'($urandom);
        cs_first = cs_n; cs_steady = 1'b1; t_rx = -1; n = 0;
        while (t_rx < 0 && n < 200) begin
            if (rx_valid === 1'b1) begin
                t_rx = cyc;
            end else begin
                if (cs_n !== cs_first) cs_steady = 1'b0;
                @(negedge clk); n++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin errors++; $display("FAIL reset_sclk_mosi got %b%b want 00", sclk, mosi); end
        checks++; if (cs_n !== 2'b11 || cs_n3 !== 3'b111) begin errors++; $display("FAIL reset_cs_n got %b/%b want 11/111", cs_n, cs_n3); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        int t0;
        logic no_pulse;
        slv_word = 8'hE7; slv_mode = 2'b00;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hA5; mode = 2'b00; cs_sel = 1'b1; t0 = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL midrst_cs_n got %b want 11", cs_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk got %b want 0", sclk); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_tx_ready got %b want 1", tx_ready); end
        no_pulse = 1'b1;
        repeat (45) begin
            if (rx_valid !== 1'b0) no_pulse = 1'b0;
            @(negedge clk);
        end
        checks++; if (no_pulse !== 1'b1) begin errors++; $display("FAIL midrst_rx_valid got pulse want none"); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data got %h want 00", rx_data); end
    endtask

    task automatic test_mode0;
        int t0, t_rx;
        logic [1:0] cs_first;
        logic cs_steady;
        do_xfer(8'hA5, 8'h3C, 2'b00, 1'b1, t0, t_rx, cs_first, cs_steady);
        checks++; if (cs_first !== 2'b01 || cs_steady !== 1'b1) begin errors++; $display("FAIL m0_cs_n got %b steady=%b want 01 steady=1", cs_first, cs_steady); end
        checks++; if (t_rx !== t0 + LAT) begin errors++; $display("FAIL m0_latency got %0d want %0d", t_rx - t0, LAT); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL m0_rx_data got %h want 3c", rx_data); end
        checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL m0_cs_n_end got %b want 11", cs_n); end
        checks++; if (mon_cap !== 8'hA5) begin errors++; $display("FAIL m0_mosi_bits got %h want a5", mon_cap); end
        checks++; if (mon_edges !== 2 * W || mon_bad !== 0) begin errors++; $display("FAIL m0_sclk got edges=%0d bad=%0d want 16/0", mon_edges, mon_bad); end
    endtask

    task automatic test_mode3;
        int t0, t_rx;
        logic [1:0] cs_first;
        logic cs_steady;
        do_xfer(8'hFF, 8'h81, 2'b11, 1'b0, t0, t_rx, cs_first, cs_steady);
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL m3_rx_data got %h want 81", rx_data); end
        checks++; if (mon_bad !== 0 || mon_cap !== 8'hFF) begin errors++; $display("FAIL m3_mosi got bad=%0d bits=%h want 0/ff", mon_bad, mon_cap); end
        checks++; if (cs_first !== 2'b10) begin errors++; $display("FAIL m3_cs_n got %b want 10", cs_first); end
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk got %b want 1", sclk); end
    endtask

    task automatic test_cs_range;
        int t0, t_rx, n;
        logic cs_ok;
        logic [2:0] cs_first;
        for (int s = 2; s <= 3; s++) begin
            @(negedge clk);
            tx_valid3 = 1'b1; tx_data3 = 8'h55; cs_sel3 = 2'(s); mode3 = 2'b00; t0 = cyc;
            @(negedge clk);
            tx_valid3 = 1'b0; cs_sel3 = 2'd0;
            cs_first = cs_n3; cs_ok = 1'b1; t_rx = -1; n = 0;
            while (t_rx < 0 && n < 200) begin
                if (rx_valid3 === 1'b1) begin
                    t_rx = cyc;
                end else begin
                    if (cs_n3 !== cs_first) cs_ok = 1'b0;
                    @(negedge clk); n++;
                end
            end
            if (s == 3) begin
                checks++; if (cs_first !== 3'b111 || cs_ok !== 1'b1) begin errors++; $display("FAIL oor_cs_n got %b steady=%b want 111", cs_first, cs_ok); end
            end else begin
                checks++; if (cs_first !== 3'b011) begin errors++; $display("FAIL sel2_cs_n got %b want 011", cs_first); end
            end
            checks++; if (t_rx !== t0 + LAT) begin errors++; $display("FAIL cs3_latency sel=%0d got %0d want %0d", s, t_rx - t0, LAT); end
            checks++; if (rx_data3 !== 8'h00) begin errors++; $display("FAIL cs3_rx_data got %h want 00", rx_data3); end
        end
    endtask

    task automatic test_back_to_back;
        int t0, t1, t2, n;
        logic [1:0] cs_prev;
        slv_word = 8'h5A; slv_mode = 2'b00;
        @(negedge clk);
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        tx_valid = 1'b1; tx_data = 8'h12; mode = 2'b00; cs_sel = 1'b0; t0 = cyc;
        @(negedge clk);
        tx_data = 8'h34;
        t1 = -1; n = 0; cs_prev = cs_n;
        while (t1 < 0 && n < 200) begin
            if (rx_valid === 1'b1) t1 = cyc;
            else begin cs_prev = cs_n; @(negedge clk); n++; end
        end
        checks++; if (t1 !== t0 + LAT) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", t1 - t0, LAT); end
        checks++; if (rx_data !== 8'h5A || mon_cap !== 8'h12) begin errors++; $display("FAIL b2b_first_data got rx=%h mosi=%h want 5a/12", rx_data, mon_cap); end
        checks++; if (tx_ready !== 1'b1 || cs_n !== 2'b11 || cs_prev !== 2'b10) begin errors++; $display("FAIL b2b_gap got ready=%b cs=%b prev=%b want 1/11/10", tx_ready, cs_n, cs_prev); end
        slv_word = 8'hC6;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (cs_n !== 2'b10) begin errors++; $display("FAIL b2b_second_accept got cs=%b want 10", cs_n); end
        t2 = -1; n = 0;
        while (t2 < 0 && n < 200) begin
            if (rx_valid === 1'b1) t2 = cyc;
            else begin @(negedge clk); n++; end
        end
        checks++; if (t2 !== t1 + LAT) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", t2 - t1, LAT); end
        checks++; if (rx_data !== 8'hC6 || mon_cap !== 8'h34) begin errors++; $display("FAIL b2b_second_data got rx=%h mosi=%h want c6/34", rx_data, mon_cap); end
    endtask

    task automatic test_random;
        int t0, t_rx;
        logic [1:0] cs_first, md, exp_cs;
        logic cs_steady, sel;
        logic [7:0] tx, slv;
        for (int k = 0; k < 8; k++) begin
            tx = 8'($urandom); slv = 8'($urandom); md = 2'($urandom); sel = 1'($urandom);
            exp_cs = 2'b11 & ~(2'b01 << sel);
            do_xfer(tx, slv, md, sel, t0, t_rx, cs_first, cs_steady);
            checks++; if (t_rx !== t0 + LAT) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", k, t_rx - t0, LAT); end
            checks++; if (rx_data !== slv) begin errors++; $display("FAIL rnd%0d_rx_data mode=%b got %h want %h", k, md, rx_data, slv); end
            checks++; if (mon_cap !== tx || mon_bad !== 0 || mon_edges !== 2 * W) begin errors++; $display("FAIL rnd%0d_mosi mode=%b got %h bad=%0d edges=%0d want %h", k, md, mon_cap, mon_bad, mon_edges, tx); end
            checks++; if (cs_first !== exp_cs || cs_steady !== 1'b1) begin errors++; $display("FAIL rnd%0d_cs_n got %b want %b", k, cs_first, exp_cs); end
            @(negedge clk);
            checks++; if (sclk !== md[1] || cs_n !== 2'b11) begin errors++; $display("FAIL rnd%0d_idle got sclk=%b cs=%b want %b/11", k, sclk, cs_n, md[1]); end
        end
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback;
        int t0, t_rx;
        logic [1:0] cs_first;
        logic cs_steady;
        loop_en = 1'b1;
        do_xfer(8'hC3, 8'h00, 2'b00, 1'b1, t0, t_rx, cs_first, cs_steady);
        loop_en = 1'b0;
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL loop_rx_data got %h want c3", rx_data); end
        checks++; if (cs_first !== 2'b11 || cs_steady !== 1'b1) begin errors++; $display("FAIL loop_cs_n got %b want 11", cs_first); end
    endtask
`endif

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; cs_sel = 1'b0; mode = 2'b00;
        tx_valid3 = 1'b0; tx_data3 = 8'h00; cs_sel3 = 2'd0; mode3 = 2'b00; miso3 = 1'b0;
        slv_word = 8'h00; slv_mode = 2'b00;
`ifdef SPI_LOOPBACK_EN
        loop_en = 1'b0; loop_en3 = 1'b0;
`endif
        test_reset;
        test_reset_mid;
        test_mode0;
        test_mode3;
        test_cs_range;
        test_back_to_back;
        test_random;
`ifdef SPI_LOOPBACK_EN
        test_loopback;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
